// File: rtl/dbg_guv_pkg.sv
// Shared widths, helpers and skid entry type for the dbg_guv log path.
package dbg_guv_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int DEST_WIDTH = 16;
    localparam int ID_WIDTH   = 16;

    function automatic int log_width(int dw, int dstw, int idw);
        return dw + dw / 8 + 1 + dstw + idw;
    endfunction

    localparam int LOG_WIDTH_DEF = log_width(DATA_WIDTH, DEST_WIDTH, ID_WIDTH);

    function automatic int src_w(int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic valid;
        logic last;
    } skid_ctl_t;

endpackage

// File: rtl/dbg_log_arb_skid.sv
// Two-entry registered skid buffer: A drives the output, B absorbs one
// flit after downstream stalls.
module dbg_log_arb_skid
    import dbg_guv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    output logic         ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready
);

    skid_ctl_t    a_ctl;
    skid_ctl_t    b_ctl;
    logic [W-1:0] a_data;
    logic [W-1:0] b_data;
    logic         drain;

    assign drain = a_ctl.valid & out_ready;
    assign ready = ~b_ctl.valid;

    // push is only ever asserted while B is empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_ctl  <= '0;
            b_ctl  <= '0;
            a_data <= '0;
            b_data <= '0;
        end else if (push && (!a_ctl.valid || drain)) begin
            a_data <= push_data;
            a_ctl  <= '{valid: 1'b1, last: push_last};
        end else if (push) begin
            b_data <= push_data;
            b_ctl  <= '{valid: 1'b1, last: push_last};
        end else if (drain) begin
            a_data <= b_data;
            a_ctl  <= b_ctl;
            b_ctl  <= '0;
        end
    end

    assign out_data  = a_data;
    assign out_valid = a_ctl.valid;
    assign out_last  = a_ctl.last;

endmodule

// File: rtl/dbg_log_arb.sv
// Packet-aware round-robin merge of N dbg_guv log streams into one output.
// DBG_LOG_ARB_SRC_TAG_EN prepends the source index to out_TDATA.
module dbg_log_arb
    import dbg_guv_pkg::*;
#(
    parameter int N_INPUTS    = 4,
    parameter int LOG_WIDTH   = LOG_WIDTH_DEF,
    parameter bit PACKET_MODE = 1'b1,
    localparam int SRC_W      = src_w(N_INPUTS),
`ifdef DBG_LOG_ARB_SRC_TAG_EN
    localparam int OUT_W      = LOG_WIDTH + SRC_W
`else
    localparam int OUT_W      = LOG_WIDTH
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_INPUTS*LOG_WIDTH-1:0] in_TDATA,
    input  logic [N_INPUTS-1:0]           in_TVALID,
    output logic [N_INPUTS-1:0]           in_TREADY,
    input  logic [N_INPUTS-1:0]           in_TLAST,
    output logic [OUT_W-1:0]              out_TDATA,
    output logic                          out_TVALID,
    input  logic                          out_TREADY,
    output logic                          out_TLAST,
    output logic                          locked,
    output logic [SRC_W-1:0]              grant
);

    logic [SRC_W-1:0]     rr_ptr;
    logic [SRC_W-1:0]     sel;
    logic [SRC_W-1:0]     nxt;
    logic [SRC_W-1:0]     idx;
    logic                 has_sel;
    logic                 skid_ready;
    logic                 xfer;
    logic                 last_in;
    logic [LOG_WIDTH-1:0] flit;
    logic [OUT_W-1:0]     push_data;
    int                   t;

    // descending scan so the closest valid source after rr_ptr wins
    always_comb begin
        sel     = '0;
        has_sel = 1'b0;
        idx     = '0;
        t       = 0;
        if (locked) begin
            sel     = grant;
            has_sel = in_TVALID[grant];
        end else begin
            for (int k = N_INPUTS - 1; k >= 0; k--) begin
                t = int'(rr_ptr) + k;
                if (t >= N_INPUTS) t = t - N_INPUTS;
                idx = SRC_W'(t);
                if (in_TVALID[idx]) begin
                    sel     = idx;
                    has_sel = 1'b1;
                end
            end
        end
    end

    always_comb begin
        flit = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (sel == SRC_W'(i)) flit = in_TDATA[i*LOG_WIDTH +: LOG_WIDTH];
        end
    end

    assign last_in = in_TLAST[sel];
    assign xfer    = has_sel & skid_ready & rst;
    assign nxt     = (sel == SRC_W'(N_INPUTS - 1)) ? '0 : sel + SRC_W'(1);

    always_comb begin
        in_TREADY = '0;
        if (xfer) in_TREADY[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            locked <= 1'b0;
            grant  <= '0;
        end else if (xfer) begin
            grant <= sel;
            if (PACKET_MODE && !last_in) begin
                locked <= 1'b1;
            end else begin
                locked <= 1'b0;
                rr_ptr <= nxt;
            end
        end
    end

`ifdef DBG_LOG_ARB_SRC_TAG_EN
    assign push_data = {sel, flit};
`else
    assign push_data = flit;
`endif

    dbg_log_arb_skid #(
        .W(OUT_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (xfer),
        .push_data (push_data),
        .push_last (last_in),
        .ready     (skid_ready),
        .out_data  (out_TDATA),
        .out_valid (out_TVALID),
        .out_last  (out_TLAST),
        .out_ready (out_TREADY)
    );

endmodule

// File: tb/tb_dbg_log_arb.sv
// Directed self-checking bench for dbg_log_arb (N=4, 69-bit flits).
module tb_dbg_log_arb;

    localparam int N  = 4;
    localparam int LW = 69;
    localparam int SW = 2;
`ifdef DBG_LOG_ARB_SRC_TAG_EN
    localparam int OW = LW + SW;
`else
    localparam int OW = LW;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N*LW-1:0] in_TDATA;
    logic [N-1:0]    in_TVALID;
    logic [N-1:0]    in_TREADY;
    logic [N-1:0]    in_TLAST;
    logic [OW-1:0]   out_TDATA;
    logic            out_TVALID;
    logic            out_TREADY;
    logic            out_TLAST;
    logic            locked;
    logic [SW-1:0]   grant;

    always #5 clk = ~clk;

    dbg_log_arb dut (
        .clk        (clk),
        .rst        (rst),
        .in_TDATA   (in_TDATA),
        .in_TVALID  (in_TVALID),
        .in_TREADY  (in_TREADY),
        .in_TLAST   (in_TLAST),
        .out_TDATA  (out_TDATA),
        .out_TVALID (out_TVALID),
        .out_TREADY (out_TREADY),
        .out_TLAST  (out_TLAST),
        .locked     (locked),
        .grant      (grant)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [LW:0]   srcq[N][$];
    logic [OW-1:0] o_data[$];
    logic          o_last[$];
    int            o_cyc[$];
    int            i_cyc[$];

    function automatic logic [LW:0] mk(input logic last, input int val);
        return {last, LW'(val)};
    endfunction

    function automatic bit busy();
        bit b;
        b = out_TVALID;
        for (int i = 0; i < N; i++) if (srcq[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() != 0) begin
                in_TVALID[i]            = 1'b1;
                in_TLAST[i]             = srcq[i][0][LW];
                in_TDATA[i*LW +: LW]    = srcq[i][0][LW-1:0];
            end else begin
                in_TVALID[i]            = 1'b0;
                in_TLAST[i]             = 1'b0;
                in_TDATA[i*LW +: LW]    = '0;
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] hs;
        #1;
        hs = in_TVALID & in_TREADY;
        if (out_TVALID && out_TREADY) begin
            o_data.push_back(out_TDATA);
            o_last.push_back(out_TLAST);
            o_cyc.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                void'(srcq[i].pop_front());
                i_cyc.push_back(cyc);
            end
        end
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (busy()) begin
            fails++;
            $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
        end
    endtask

    task automatic clear_logs();
        o_data.delete();
        o_last.delete();
        o_cyc.delete();
        i_cyc.delete();
    endtask

    task automatic test_reset();
        out_TREADY = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_TVALID !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", out_TVALID); end
        checks++;
        if (out_TLAST !== 1'b0) begin fails++; $display("FAIL rst_last: got %b want 0", out_TLAST); end
        checks++;
        if (out_TDATA !== '0) begin fails++; $display("FAIL rst_data: got %0h want 0", out_TDATA); end
        checks++;
        if (in_TREADY !== '0) begin fails++; $display("FAIL rst_tready: got %b want 0", in_TREADY); end
        checks++;
        if (locked !== 1'b0) begin fails++; $display("FAIL rst_locked: got %b want 0", locked); end
        checks++;
        if (grant !== '0) begin fails++; $display("FAIL rst_grant: got %0d want 0", grant); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_source();
        logic [LW-1:0] e;
        clear_logs();
        for (int k = 0; k < 4; k++) srcq[2].push_back(mk(k == 3, 'h10 + k));
        drive();
        drain(40);
        checks++;
        if (o_data.size() != 4) begin fails++; $display("FAIL single_count: got %0d want 4", o_data.size()); end
        for (int k = 0; k < 4; k++) begin
            e = LW'('h10 + k);
            checks++;
            if (k >= o_data.size()) begin
                fails++; $display("FAIL single_data[%0d]: missing, want %0h", k, e);
            end else if (o_data[k][LW-1:0] !== e || o_last[k] !== (k == 3)) begin
                fails++;
                $display("FAIL single_data[%0d]: got %0h/%b want %0h/%b", k, o_data[k][LW-1:0], o_last[k], e, k == 3);
            end
        end
        checks++;
        if (o_cyc.size() != 4 || i_cyc.size() == 0 || o_cyc[0] != i_cyc[0] + 1 || o_cyc[3] != o_cyc[0] + 3) begin
            fails++; $display("FAIL single_timing: first out cycle vs first xfer mismatch or gaps");
        end
        checks++;
        if (grant !== 2'd2) begin fails++; $display("FAIL single_grant: got %0d want 2", grant); end
        checks++;
        if (locked !== 1'b0) begin fails++; $display("FAIL single_unlock: got %b want 0", locked); end
        clear_logs();
        srcq[2].push_back(mk(1'b1, 'h20));
        srcq[3].push_back(mk(1'b1, 'h30));
        drive();
        drain(20);
        checks++;
        if (o_data.size() != 2 || o_data[0][LW-1:0] !== LW'('h30) || o_data[1][LW-1:0] !== LW'('h20)) begin
            fails++; $display("FAIL rr_ptr_after_src2: order wrong, want 30 then 20 (%0d outs)", o_data.size());
        end
        checks++;
        if (o_cyc.size() != 2 || o_cyc[1] != o_cyc[0] + 1) begin
            fails++; $display("FAIL rr_ptr_bubble: gap between grants");
        end
    endtask

    task automatic test_packet_lock();
        logic [LW-1:0] exp[5];
        int viol;
        exp  = '{LW'('h100), LW'('h101), LW'('h102), LW'('h110), LW'('h111)};
        viol = 0;
        clear_logs();
        srcq[0].push_back(mk(1'b0, 'h100));
        srcq[0].push_back(mk(1'b0, 'h101));
        srcq[0].push_back(mk(1'b1, 'h102));
        srcq[1].push_back(mk(1'b0, 'h110));
        srcq[1].push_back(mk(1'b1, 'h111));
        drive();
        for (int n = 0; n < 40 && busy(); n++) begin
            #1;
            if (srcq[0].size() != 0 && in_TREADY[1]) viol++;
            step();
        end
        checks++;
        if (busy()) begin fails++; $display("FAIL lock_timeout: still busy, required idle"); end
        checks++;
        if (viol != 0) begin fails++; $display("FAIL lock_stall: src1 ready %0d cycles while src0 locked, want 0", viol); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= o_data.size()) begin
                fails++; $display("FAIL lock_data[%0d]: missing, want %0h", k, exp[k]);
            end else if (o_data[k][LW-1:0] !== exp[k]) begin
                fails++; $display("FAIL lock_data[%0d]: got %0h want %0h", k, o_data[k][LW-1:0], exp[k]);
            end
        end
        checks++;
        if (o_cyc.size() != 5 || o_cyc[3] != o_cyc[2] + 1) begin
            fails++; $display("FAIL lock_handover: src1 not on cycle after src0 last");
        end
    endtask

    task automatic test_fairness();
        logic [LW-1:0] exp[8];
        int gaps;
        exp = '{LW'('h230), LW'('h200), LW'('h210), LW'('h220),
                LW'('h231), LW'('h201), LW'('h211), LW'('h221)};
        srcq[2].push_back(mk(1'b1, 'h2f0));
        drive();
        drain(20);
        clear_logs();
        for (int i = 0; i < N; i++) begin
            srcq[i].push_back(mk(1'b1, 'h200 + 16 * i));
            srcq[i].push_back(mk(1'b1, 'h201 + 16 * i));
        end
        drive();
        drain(40);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (k >= o_data.size()) begin
                fails++; $display("FAIL fair_order[%0d]: missing, want %0h", k, exp[k]);
            end else if (o_data[k][LW-1:0] !== exp[k]) begin
                fails++; $display("FAIL fair_order[%0d]: got %0h want %0h", k, o_data[k][LW-1:0], exp[k]);
            end
        end
        gaps = 0;
        for (int k = 1; k < o_cyc.size(); k++) if (o_cyc[k] != o_cyc[k-1] + 1) gaps++;
        checks++;
        if (gaps != 0 || o_cyc.size() != 8) begin
            fails++; $display("FAIL fair_bubbles: got %0d gaps over %0d outs, want 0 over 8", gaps, o_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        int n0;
        clear_logs();
        for (int k = 0; k < 6; k++) srcq[0].push_back(mk(k == 5, 'h300 + k));
        drive();
        for (int n = 0; n < 20 && i_cyc.size() < 2; n++) step();
        out_TREADY = 1'b0;
        n0 = i_cyc.size();
        repeat (5) step();
        checks++;
        if (i_cyc.size() - n0 != 1) begin
            fails++; $display("FAIL bp_extra: got %0d flits accepted during stall, want 1", i_cyc.size() - n0);
        end
        #1;
        checks++;
        if (in_TREADY !== '0) begin fails++; $display("FAIL bp_tready: got %b want 0", in_TREADY); end
        checks++;
        if (out_TVALID !== 1'b1) begin fails++; $display("FAIL bp_hold: got %b want 1", out_TVALID); end
        out_TREADY = 1'b1;
        drain(40);
        checks++;
        if (o_data.size() != 6) begin fails++; $display("FAIL bp_count: got %0d want 6", o_data.size()); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (k >= o_data.size()) begin
                fails++; $display("FAIL bp_data[%0d]: missing, want %0h", k, 'h300 + k);
            end else if (o_data[k][LW-1:0] !== LW'('h300 + k)) begin
                fails++; $display("FAIL bp_data[%0d]: got %0h want %0h", k, o_data[k][LW-1:0], 'h300 + k);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_logs();
        for (int k = 0; k < 4; k++) srcq[1].push_back(mk(k == 3, 'h400 + k));
        drive();
        for (int n = 0; n < 20 && i_cyc.size() < 1; n++) step();
        #1;
        checks++;
        if (locked !== 1'b1) begin fails++; $display("FAIL mid_locked: got %b want 1", locked); end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_TVALID !== 1'b0) begin fails++; $display("FAIL arst_valid: got %b want 0", out_TVALID); end
        checks++;
        if (locked !== 1'b0) begin fails++; $display("FAIL arst_locked: got %b want 0", locked); end
        checks++;
        if (grant !== '0) begin fails++; $display("FAIL arst_grant: got %0d want 0", grant); end
        checks++;
        if (in_TREADY !== '0) begin fails++; $display("FAIL arst_tready: got %b want 0", in_TREADY); end
        checks++;
        if (out_TDATA !== '0) begin fails++; $display("FAIL arst_data: got %0h want 0", out_TDATA); end
        for (int i = 0; i < N; i++) srcq[i].delete();
        drive();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        clear_logs();
        srcq[0].push_back(mk(1'b1, 'h500));
        srcq[3].push_back(mk(1'b1, 'h530));
        drive();
        drain(20);
        checks++;
        if (o_data.size() != 2 || o_data[0][LW-1:0] !== LW'('h500) || o_data[1][LW-1:0] !== LW'('h530)) begin
            fails++; $display("FAIL arst_restart: want 500 then 530 (%0d outs)", o_data.size());
        end
    endtask

`ifdef DBG_LOG_ARB_SRC_TAG_EN
    task automatic test_src_tag();
        logic [OW-1:0] e;
        e = {2'd3, 69'h1};
        clear_logs();
        srcq[3].push_back(mk(1'b1, 1));
        drive();
        drain(20);
        checks++;
        if (o_data.size() != 1) begin
            fails++; $display("FAIL tag_count: got %0d want 1", o_data.size());
        end else if (o_data[0] !== e) begin
            fails++; $display("FAIL tag_data: got %0h want %0h", o_data[0], e);
        end
    endtask
`endif

    initial begin
        in_TDATA   = '0;
        in_TVALID  = '0;
        in_TLAST   = '0;
        out_TREADY = 1'b1;
        test_reset();
        test_single_source();
        test_packet_lock();
        test_fairness();
        test_backpressure();
        test_reset_mid_packet();
`ifdef DBG_LOG_ARB_SRC_TAG_EN
        test_src_tag();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dbg_log_arb.md
# dbg_log_arb

Round-robin arbiter that merges the concatenated log streams of N daisy-chained `dbg_guv` instances into one AXI-Stream log output for a single capture FIFO/DMA. Arbitration is packet-aware: once a source wins, it holds the output until its TLAST flit is accepted. A two-entry skid buffer on the output registers all output signals and sustains one flit per cycle.

## Interface
- `N_INPUTS`, 4: number of log sources; must be ≥2, need not be a power of two.
- `LOG_WIDTH`, 69: width of one log flit, equal to DATA_WIDTH + DATA_WIDTH/8 + 1 + DEST_WIDTH + ID_WIDTH (32/16/16 gives 69).
- `PACKET_MODE`, 1: 1 holds the grant until TLAST; 0 re-arbitrates after every flit.
- `SRC_W`, localparam: $clog2(N_INPUTS).

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `in_TDATA` input N_INPUTS*LOG_WIDTH: flattened source flits; source i occupies [i*LOG_WIDTH +: LOG_WIDTH].
- `in_TVALID` input N_INPUTS: per-source valid.
- `in_TREADY` output N_INPUTS: per-source ready; at most one bit is high.
- `in_TLAST` input N_INPUTS: per-source last.
- `out_TDATA` output LOG_WIDTH (+SRC_W, see Configuration): merged flit.
- `out_TVALID` output 1: merged valid.
- `out_TREADY` input 1: downstream ready.
- `out_TLAST` output 1: merged last.
- `locked` output 1: high while a packet is in progress (grant held).
- `grant` output SRC_W: current or most recent granted source index.

## Operation
- **State:** `rr_ptr` (SRC_W), `locked`, `grant`, skid entries A (output) and B (overflow), each holding {data, last, src} plus a valid bit.
- **Unlocked:** combinationally select the first i with `in_TVALID[i]` high, searching from `rr_ptr` upward and wrapping from N_INPUTS-1 to 0. If no input is valid, there is no grant and all `in_TREADY` bits are 0.
- **Accept:** `in_TREADY[g]` = (g is the selected source) && !B_valid. A transfer occurs when `in_TVALID[g]` && `in_TREADY[g]`.
- **Lock (PACKET_MODE=1):**
  - A transfer with TLAST=0 sets `locked` and holds `grant=g`.
  - While locked, only `grant` is eligible and other sources stall even if they are valid.
  - A transfer with TLAST=1 clears `locked` and sets `rr_ptr` to (g+1) mod N_INPUTS.
  - A single-flit packet (TLAST=1 on the first flit) never sets `locked`.
- **PACKET_MODE=0:** `locked` stays 0. Every transfer sets `rr_ptr` to (g+1) mod N_INPUTS.
- **Skid buffer:**
  - A transfer loads A if A is empty or is draining this cycle (out_TREADY high); otherwise it loads B.
  - When A drains and B is valid, B moves to A.
  - `out_*` are driven directly from A.
- **Simultaneous events:** if TLAST is accepted while other sources are valid, the next cycle's grant is the next valid source after the old grant, with no idle bubble. Downstream backpressure never drops or duplicates a flit.
- **Reset:** asserting `rst` low at any time, including mid-packet, asynchronously clears A, B, `locked`, `rr_ptr=0` and `grant=0`. All outputs then read 0: `out_TVALID=0`, `out_TLAST=0`, `out_TDATA=0`, `in_TREADY=0`, `locked=0`, `grant=0`. A partial packet is discarded; sources must also be reset.

## Timing
- Latency from input transfer to `out_TVALID` is 1 cycle.
- Throughput is 1 flit/cycle while `out_TREADY` is high, including across grant changes.
- `in_TREADY` is combinational from `in_TVALID`, `locked`, `rr_ptr` and the registered `B_valid`. It never depends on `out_TREADY` in the same cycle.
- All `out_*`, `locked` and `grant` are registered.
- After `out_TREADY` falls, at most 1 more flit is accepted (into B), then `in_TREADY` goes low until B empties.

## Configuration
- `DBG_LOG_ARB_SRC_TAG_EN`
  - **Defined:** `out_TDATA` is LOG_WIDTH+SRC_W wide, formed as {src, log_flit}, with the source index in the MSBs.
  - **Undefined:** `out_TDATA` is exactly LOG_WIDTH wide and the src field is not stored in the skid entries.

## Structure
- Shared package `dbg_guv_pkg`: LOG_WIDTH derivation function, default widths (32/16/16), `SRC_W` helper, and the skid entry struct typedef.
- Sub-module `dbg_log_arb_skid`: the two-entry registered skid buffer, parameterised by width. Arbitration and lock logic stay in the top module.

## Test plan
- **Single source:** src2 streams 0x10..0x13 with TLAST on 0x13, out_TREADY=1 → out emits 0x10..0x13 on cycles 1–4 after the first transfer, grant=2, then rr_ptr=3.
- **Packet lock:** src0 sends a 3-flit packet while src1 is valid throughout → src1's in_TREADY stays 0 until src0's TLAST is accepted; src1's first flit appears on out the cycle immediately after src0's last flit.
- **Fairness with wrap:** all 4 sources continuously valid with 1-flit packets, starting from rr_ptr=3 → grant order 3,0,1,2,3 with no idle cycles.
- **Backpressure:** out_TREADY=0 for 5 cycles mid-packet → exactly 1 extra flit is accepted, then in_TREADY=0; after release, all flits arrive in order with none lost or duplicated.
- **Reset mid-packet:** rst low during the 2nd of 4 flits → out_TVALID=0, locked=0 and grant=0 immediately (asynchronously); after release, arbitration restarts from src0.
- **DBG_LOG_ARB_SRC_TAG_EN:** src3 sends 0x1 → out_TDATA = {2'd3, 69'h1}.
